// File: rtl/multi_tick_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tick_pkg
//  Purpose  : Shared types and helpers for multi_tick_divider and its
//             per-channel counters.
//             - ch_state_e    : channel FSM states (IDLE, RUN)
//             - c_min_sel_w   : narrowest legal channel-select width
//             - cfg_ch_width(): channel-select width for a channel count
//             - sat_div()     : maps a programmed divisor of 0 to 1
//  Revision : 1.0  initial release
// ============================================================================
package tick_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // A single-channel build still needs a one-bit select port.
  localparam int unsigned c_min_sel_w = 1;

  function automatic int unsigned cfg_ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : c_min_sel_w;
  endfunction

  // A divisor of 0 has no meaning; treat it as "pulse on every base tick".
  function automatic logic [31:0] sat_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage : tick_pkg
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tick_channel
//  Purpose  : One programmable divider channel. Counts base ticks while in
//             RUN and emits a one-cycle pulse every `div` ticks, either
//             periodically or once (one-shot, then back to IDLE).
//  Ports    : clk, reset        clock / synchronous active-high reset
//             i_base_tick       one-cycle prescaler tick
//             i_start, i_stop   (re)start / stop strobes, stop has priority
//             i_cfg_we          write strobe for this channel's config
//             i_cfg_div         divisor (0 is stored as 1)
//             i_cfg_oneshot     1 = one-shot, 0 = periodic
//             o_pulse           registered one-cycle output pulse
//             o_active          channel is in RUN
//  Revision : 1.0  initial release
// ============================================================================
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned CH_WIDTH    = 16,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_base_tick,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_cfg_we,
  input  logic [CH_WIDTH-1:0] i_cfg_div,
  input  logic                i_cfg_oneshot,
  output logic                o_pulse,
  output logic                o_active
);

  localparam logic [CH_WIDTH-1:0] c_one         = CH_WIDTH'(1);
  localparam logic [CH_WIDTH-1:0] c_default_div = CH_WIDTH'(sat_div(32'(DEFAULT_DIV)));

  ch_state_e           state_q,   state_d;
  logic [CH_WIDTH-1:0] cnt_q,     cnt_d;
  logic [CH_WIDTH-1:0] div_q,     div_d;
  logic                oneshot_q, oneshot_d;
  logic                pulse_q,   pulse_d;

  // ">=" rather than "==" so that shrinking the divisor below the current
  // count fires on the next tick instead of waiting for a counter wrap.
  // div_q is never 0, so div_q - 1 cannot underflow.
  logic w_terminal;
  assign w_terminal = (cnt_q >= (div_q - c_one));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    pulse_d   = 1'b0;

    // Config lands in the next cycle and is used right away, even in RUN;
    // the running count is deliberately left alone.
    if (i_cfg_we) begin
      div_d     = CH_WIDTH'(sat_div(32'(i_cfg_div)));
      oneshot_d = i_cfg_oneshot;
    end

    if (i_stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (i_start) begin
      // A base tick in the start cycle is intentionally not counted.
      state_d = RUN;
      cnt_d   = '0;
    end else if ((state_q == RUN) && i_base_tick) begin
      if (w_terminal) begin
        pulse_d = 1'b1;
        cnt_d   = '0;
        if (oneshot_q) begin
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q + c_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= c_default_div;
      oneshot_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      pulse_q   <= pulse_d;
    end
  end

  assign o_pulse  = pulse_q;
  assign o_active = (state_q == RUN);

endmodule : tick_channel
`default_nettype wire

// File: rtl/multi_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : multi_tick_divider
//  Purpose  : Shared prescaler producing a base tick every MAX_COUNT clocks,
//             fanned out to NUM_CH independently programmable divider
//             channels (periodic or one-shot, start/stop controlled).
//  Ports    : clk          system clock
//             reset        synchronous active-high reset
//             enable       prescaler run; low pauses all timing
//             cfg_we       channel config write strobe
//             cfg_ch       channel selected for the write (out of range ignored)
//             cfg_div      divisor (0 is stored as 1)
//             cfg_oneshot  1 = one-shot, 0 = periodic
//             start, stop  per-channel strobes
//             base_tick    one-cycle prescaler tick
//             pulse        per-channel one-cycle output pulses
//             active       per-channel RUN indication
//  Revision : 1.0  initial release
// ============================================================================
module multi_tick_divider
  import tick_pkg::*;
#(
  parameter  int unsigned CTR_WIDTH   = 22,
  parameter  int unsigned MAX_COUNT   = 500000,
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned CH_WIDTH    = 16,
  parameter  int unsigned DEFAULT_DIV = 1,
  localparam int unsigned CH_SEL_W    = cfg_ch_width(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [CH_SEL_W-1:0] cfg_ch,
  input  logic [CH_WIDTH-1:0] cfg_div,
  input  logic                cfg_oneshot,
  input  logic [NUM_CH-1:0]   start,
  input  logic [NUM_CH-1:0]   stop,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   pulse,
  output logic [NUM_CH-1:0]   active
);

  localparam logic [CTR_WIDTH-1:0] c_last    = CTR_WIDTH'(MAX_COUNT - 1);
  localparam logic [CTR_WIDTH-1:0] c_ctr_one = CTR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Prescaler. Holding the count while disabled stretches the current period
  // by exactly the paused cycles, so no tick is lost or duplicated.
  // --------------------------------------------------------------------------
  logic [CTR_WIDTH-1:0] count_q, count_d;
  logic                 base_tick_q, base_tick_d;

  always_comb begin
    count_d     = count_q;
    base_tick_d = 1'b0;
    if (enable) begin
      if (count_q == c_last) begin
        count_d     = '0;
        base_tick_d = 1'b1;
      end else begin
        count_d = count_q + c_ctr_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      base_tick_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      base_tick_q <= base_tick_d;
    end
  end

  assign base_tick = base_tick_q;

  // --------------------------------------------------------------------------
  // Config decode and channel fan-out. A cfg_ch value with no matching
  // channel simply selects nothing.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_ch_we[i] = cfg_we && (cfg_ch == CH_SEL_W'(i));

    tick_channel #(
      .CH_WIDTH    (CH_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .i_base_tick   (base_tick_q),
      .i_start       (start[i]),
      .i_stop        (stop[i]),
      .i_cfg_we      (w_ch_we[i]),
      .i_cfg_div     (cfg_div),
      .i_cfg_oneshot (cfg_oneshot),
      .o_pulse       (pulse[i]),
      .o_active      (active[i])
    );
  end : g_ch

endmodule : multi_tick_divider
`default_nettype wire

// File: tb/tb_multi_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_tick_divider
//  Purpose  : Scoreboard bench for multi_tick_divider (MAX_COUNT=5, NUM_CH=2,
//             CH_WIDTH=4). Stimulus pushes the hand-computed cycle numbers at
//             which base_tick / pulse[0] / pulse[1] must appear; a monitor
//             pops and compares whenever the DUT raises one of them.
//             Cycle numbering: cyc counts rising edges; t0 is the cyc value
//             at the falling edge where reset is released and enable raised,
//             so the first base tick is seen at t0+5.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_tick_divider;

  localparam int unsigned MAX_COUNT = 5;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned CH_WIDTH  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                cfg_we;
  logic [0:0]          cfg_ch;
  logic [CH_WIDTH-1:0] cfg_div;
  logic                cfg_oneshot;
  logic [NUM_CH-1:0]   start;
  logic [NUM_CH-1:0]   stop;
  logic                base_tick;
  logic [NUM_CH-1:0]   pulse;
  logic [NUM_CH-1:0]   active;

  multi_tick_divider #(
    .CTR_WIDTH   (3),
    .MAX_COUNT   (MAX_COUNT),
    .NUM_CH      (NUM_CH),
    .CH_WIDTH    (CH_WIDTH),
    .DEFAULT_DIV (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .base_tick   (base_tick),
    .pulse       (pulse),
    .active      (active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int q_tick[$];
  int q_p0[$];
  int q_p1[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (base_tick === 1'b1) begin
        if (q_tick.size() == 0) chk("unexpected base_tick at cycle", cyc, -1);
        else                    chk("base_tick cycle", cyc, q_tick.pop_front());
      end
      if (pulse[0] === 1'b1) begin
        if (q_p0.size() == 0) chk("unexpected pulse[0] at cycle", cyc, -1);
        else                  chk("pulse[0] cycle", cyc, q_p0.pop_front());
      end
      if (pulse[1] === 1'b1) begin
        if (q_p1.size() == 0) chk("unexpected pulse[1] at cycle", cyc, -1);
        else                  chk("pulse[1] cycle", cyc, q_p1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Assert reset at the current falling edge, check the post-reset outputs
  // one edge later, then release reset with enable high.
  task automatic do_reset(output int t0);
    reset  = 1'b1;
    enable = 1'b0;
    start  = '0;
    stop   = '0;
    cfg_we = 1'b0;
    @(negedge clk);
    chk("reset base_tick", int'(base_tick), 0);
    chk("reset pulse",     int'(pulse),     0);
    chk("reset active",    int'(active),    0);
    reset  = 1'b0;
    enable = 1'b1;
    t0     = cyc;
  endtask

  task automatic cfg_write(input int ch, input int div, input int os);
    cfg_we      = 1'b1;
    cfg_ch      = 1'(ch);
    cfg_div     = CH_WIDTH'(div);
    cfg_oneshot = 1'(os);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic push_ticks(input int t0, input int first, input int last);
    for (int t = first; t <= last; t += 5) q_tick.push_back(t0 + t);
  endtask

  task automatic chk_drained(input string phase);
    chk({phase, " base_ticks missing"}, q_tick.size(), 0);
    chk({phase, " pulse[0] missing"},   q_p0.size(),   0);
    chk({phase, " pulse[1] missing"},   q_p1.size(),   0);
  endtask

  initial begin
    int t0;
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_oneshot = 1'b0; start = '0; stop = '0;

    // ---- Prescaler alone --------------------------------------------------
    do_reset(t0);
    push_ticks(t0, 5, 15);
    wait_until(t0 + 16);
    chk("idle pulse",  int'(pulse),  0);
    chk("idle active", int'(active), 0);
    wait_until(t0 + 17);
    chk_drained("prescaler");

    // ---- ch0 div 3 periodic, then stop -------------------------------------
    do_reset(t0);
    push_ticks(t0, 5, 65);
    q_p0.push_back(t0 + 16); q_p0.push_back(t0 + 31); q_p0.push_back(t0 + 46);
    wait_until(t0 + 1);
    cfg_write(0, 3, 0);
    start[0] = 1'b1; wait_until(t0 + 3); start[0] = 1'b0;
    wait_until(t0 + 20);
    chk("ch0 active while running", int'(active[0]), 1);
    wait_until(t0 + 48);
    stop[0] = 1'b1; wait_until(t0 + 49); stop[0] = 1'b0;
    wait_until(t0 + 50);
    chk("ch0 active after stop", int'(active[0]), 0);
    wait_until(t0 + 67);
    chk_drained("periodic");

    // ---- ch1 div 2 one-shot + restart; ch0 start&stop same cycle ----------
    do_reset(t0);
    push_ticks(t0, 5, 45);
    q_p1.push_back(t0 + 11); q_p1.push_back(t0 + 36);
    wait_until(t0 + 1);
    cfg_write(1, 2, 1);
    start = 2'b11; stop = 2'b01;
    wait_until(t0 + 3);
    start = '0; stop = '0;
    wait_until(t0 + 5);
    chk("ch0 start+stop ends idle", int'(active[0]), 0);
    chk("ch1 oneshot active",       int'(active[1]), 1);
    wait_until(t0 + 13);
    chk("ch1 idle after oneshot",   int'(active[1]), 0);
    wait_until(t0 + 26);
    start[1] = 1'b1; wait_until(t0 + 27); start[1] = 1'b0;
    wait_until(t0 + 30);
    chk("ch1 active after restart", int'(active[1]), 1);
    wait_until(t0 + 40);
    chk("ch1 idle after 2nd shot",  int'(active[1]), 0);
    wait_until(t0 + 47);
    chk_drained("oneshot");

    // ---- enable paused for 7 cycles ---------------------------------------
    do_reset(t0);
    q_tick.push_back(t0 + 5);  q_tick.push_back(t0 + 10);
    q_tick.push_back(t0 + 22); q_tick.push_back(t0 + 27);
    q_tick.push_back(t0 + 32); q_tick.push_back(t0 + 37);
    q_p0.push_back(t0 + 11); q_p0.push_back(t0 + 28); q_p0.push_back(t0 + 38);
    wait_until(t0 + 1);
    cfg_write(0, 2, 0);
    start[0] = 1'b1; wait_until(t0 + 3); start[0] = 1'b0;
    wait_until(t0 + 12);
    enable = 1'b0;
    wait_until(t0 + 19);
    enable = 1'b1;
    wait_until(t0 + 40);
    chk_drained("pause");

    // ---- divisor rewrite while running; start on a base tick ---------------
    do_reset(t0);
    push_ticks(t0, 5, 55);
    q_p0.push_back(t0 + 31); q_p0.push_back(t0 + 41);
    q_p0.push_back(t0 + 46); q_p0.push_back(t0 + 51);
    q_p1.push_back(t0 + 21); q_p1.push_back(t0 + 31);
    q_p1.push_back(t0 + 41); q_p1.push_back(t0 + 51);
    wait_until(t0 + 1);
    cfg_write(0, 8, 0);
    start[0] = 1'b1;
    cfg_write(1, 2, 0);
    start[0] = 1'b0;
    wait_until(t0 + 10);
    start[1] = 1'b1; wait_until(t0 + 11); start[1] = 1'b0;
    wait_until(t0 + 20);
    chk("ch0 active div8", int'(active[0]), 1);
    wait_until(t0 + 27);
    cfg_write(0, 2, 0);
    wait_until(t0 + 42);
    cfg_write(0, 0, 0);
    wait_until(t0 + 52);
    stop = 2'b11; wait_until(t0 + 53); stop = '0;
    wait_until(t0 + 54);
    chk("both idle after stop", int'(active), 0);
    wait_until(t0 + 57);
    chk_drained("rewrite");

    // ---- reset with a pulse pending ---------------------------------------
    do_reset(t0);
    q_tick.push_back(t0 + 5); q_tick.push_back(t0 + 10);
    q_p0.push_back(t0 + 6);
    wait_until(t0 + 2);
    start[0] = 1'b1; wait_until(t0 + 3); start[0] = 1'b0;
    wait_until(t0 + 8);
    chk("ch0 active div1", int'(active[0]), 1);
    wait_until(t0 + 10);
    do_reset(t0);
    wait_until(t0 + 3);
    chk_drained("reset pending");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multi_tick_divider
`default_nettype wire
